// File: rtl/eth_stats_pkg.sv
// Shared constants for the Ethernet MAC statistics block: event bit positions
// within status_vector, the default error set and status-word field offsets.
package eth_stats_pkg;

  localparam int EV_TX_OVF       = 0;
  localparam int EV_TX_BAD       = 1;
  localparam int EV_TX_GOOD      = 2;
  localparam int EV_TX_UNDERFLOW = 3;
  localparam int EV_RX_BAD       = 4;
  localparam int EV_RX_FCS       = 5;
  localparam int EV_RX_OVF       = 6;
  localparam int EV_RX_FIFO_BAD  = 7;
  localparam int EV_RX_GOOD      = 8;

  localparam int MAX_EVENTS = EV_RX_GOOD + 1;
  localparam int SPEED_LSB  = 9;

  localparam logic [MAX_EVENTS-1:0] ERR_MASK_DEFAULT =
    (9'(1) << EV_TX_BAD) | (9'(1) << EV_TX_UNDERFLOW) | (9'(1) << EV_RX_BAD) |
    (9'(1) << EV_RX_FCS) | (9'(1) << EV_RX_OVF)       | (9'(1) << EV_RX_FIFO_BAD);

  // Status word layout: {zero-pad, speed_changed, speed[1:0], err_sticky[n-1:0]}
  localparam int ST_ERR_LSB = 0;

  function automatic int st_speed_lsb(input int num_events);
    return num_events;
  endfunction

  function automatic int st_changed_bit(input int num_events);
    return num_events + 2;
  endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// One live event counter: synchronous clear (that still counts a coincident
// event) and either saturating or wrapping increment.
module eth_stat_counter #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock125,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock125) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc) begin
      if (&count) begin
        count <= SATURATE ? count : '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/eth_status_counters.sv
// MAC statistics block: per-event counters with atomic shadow snapshot,
// host read port, sticky error bits, maskable irq and link-speed tracking.
module eth_status_counters
  import eth_stats_pkg::*;
#(
  parameter int                    NUM_EVENTS    = 9,
  parameter int                    COUNTER_WIDTH = 32,
  parameter bit                    SATURATE      = 1'b1,
  parameter logic [MAX_EVENTS-1:0] ERROR_MASK    = ERR_MASK_DEFAULT,
  parameter int                    ADDR_WIDTH    = 4
) (
  input  logic                     clock125,
  input  logic                     reset,
  input  logic [15:0]              status_vector,
  input  logic                     snapshot,
  input  logic                     clr_en,
  input  logic [NUM_EVENTS-1:0]    clr_mask,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  input  logic [NUM_EVENTS-1:0]    irq_mask,
  input  logic                     irq_ack,
  output logic                     irq,
  output logic [1:0]               speed
);

  localparam int STAT_W = st_changed_bit(NUM_EVENTS) + 1;
  localparam int MUX_W  = (COUNTER_WIDTH > STAT_W) ? COUNTER_WIDTH : STAT_W;

  logic [NUM_EVENTS-1:0]    events;
  logic [NUM_EVENTS-1:0]    err_events;
  logic [NUM_EVENTS-1:0]    err_sticky;
  logic                     speed_changed;
  logic                     prime;
  logic [1:0]               speed_sample;
  logic [COUNTER_WIDTH-1:0] live   [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] shadow [NUM_EVENTS];
  logic [STAT_W-1:0]        status_word;
  logic [MUX_W-1:0]         status_ext;
  logic [COUNTER_WIDTH-1:0] rd_mux;
  logic                     unused_status;

  assign events        = status_vector[NUM_EVENTS-1:0];
  assign err_events    = events & ERROR_MASK[NUM_EVENTS-1:0];
  assign speed_sample  = status_vector[SPEED_LSB+1:SPEED_LSB];
  assign unused_status = ^status_vector;

  for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_cnt
    eth_stat_counter #(
      .WIDTH    (COUNTER_WIDTH),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clock125 (clock125),
      .reset    (reset),
      .inc      (events[gi]),
      .clr      (clr_en & clr_mask[gi]),
      .count    (live[gi])
    );
  end

  // Shadows take the pre-update live value, so snapshot+clear keeps the old count.
  always_ff @(posedge clock125) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= '0;
    end else if (snapshot) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= live[i];
    end
  end

  assign status_word = {speed_changed, speed, err_sticky};
  assign status_ext  = MUX_W'(status_word);

  always_comb begin
    rd_mux = '0;
    if (rd_addr == ADDR_WIDTH'(NUM_EVENTS)) rd_mux = status_ext[COUNTER_WIDTH-1:0];
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) rd_mux = shadow[i];
    end
  end

  // Read handshake: rd_en is always accepted (no back-pressure); rd_valid pulses
  // one cycle later alongside rd_data, which otherwise holds its last value.
  always_ff @(posedge clock125) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  // New set conditions win over a coincident acknowledge.
  always_ff @(posedge clock125) begin
    if (reset) begin
      err_sticky    <= '0;
      speed_changed <= 1'b0;
      prime         <= 1'b0;
      speed         <= 2'b00;
      irq           <= 1'b0;
    end else begin
      prime         <= 1'b1;
      speed         <= speed_sample;
      speed_changed <= (prime && (speed_sample != speed)) | (speed_changed & ~irq_ack);
      err_sticky    <= (irq_ack ? '0 : err_sticky) | err_events;
      irq           <= |(err_sticky & irq_mask);
    end
  end

endmodule

// File: tb/tb_eth_status_counters.sv
// Directed bench for eth_status_counters: a default 32-bit instance plus two
// 8-bit instances (saturating and wrapping) sharing the same stimulus.
module tb_eth_status_counters;
  import eth_stats_pkg::*;

  // clock / reset
  logic clock125 = 1'b0;
  always #5 clock125 = ~clock125;

  logic        reset = 1'b1;
  logic [8:0]  ev    = '0;
  logic [1:0]  spd   = 2'b00;
  logic [15:0] status_vector;
  logic        snapshot = 1'b0;
  logic        clr_en   = 1'b0;
  logic [8:0]  clr_mask = '0;
  logic        rd_en    = 1'b0;
  logic [3:0]  rd_addr  = '0;
  logic [8:0]  irq_mask = '0;
  logic        irq_ack  = 1'b0;

  assign status_vector = {5'b0, spd, ev};

  logic [31:0] rd_data;
  logic        rd_valid, irq;
  logic [1:0]  speed;
  logic [7:0]  rd_data_s8, rd_data_w8;
  logic        rd_valid_s8, rd_valid_w8, irq_s8, irq_w8;
  logic [1:0]  speed_s8, speed_w8;

  eth_status_counters dut (
    .clock125(clock125), .reset(reset), .status_vector(status_vector),
    .snapshot(snapshot), .clr_en(clr_en), .clr_mask(clr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq), .speed(speed)
  );

  eth_status_counters #(.COUNTER_WIDTH(8), .SATURATE(1'b1)) dut_s8 (
    .clock125(clock125), .reset(reset), .status_vector(status_vector),
    .snapshot(snapshot), .clr_en(clr_en), .clr_mask(clr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s8), .rd_valid(rd_valid_s8),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq_s8), .speed(speed_s8)
  );

  eth_status_counters #(.COUNTER_WIDTH(8), .SATURATE(1'b0)) dut_w8 (
    .clock125(clock125), .reset(reset), .status_vector(status_vector),
    .snapshot(snapshot), .clr_en(clr_en), .clr_mask(clr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w8), .rd_valid(rd_valid_w8),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .irq(irq_w8), .speed(speed_w8)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_rd [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock125);
    #1;
  endtask

  task automatic pulse(input logic [8:0] bits, input int n);
    ev = bits;
    repeat (n) step();
    ev = '0;
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [63:0] exp);
    rd_en   = 1'b1;
    rd_addr = 4'(addr);
    exp_q.push_back(exp);
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), exp_q.pop_front());
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_speed", 64'(speed), 64'd0);
    reset = 1'b0;
    step();
    read_chk("rst_shadow0", 0, 64'd0);

    // saturation vs wrap on rx good (300 pulses)
    pulse(9'h100, 300);
    snapshot = 1'b1; step(); snapshot = 1'b0;
    read_chk("cnt32_ev8", EV_RX_GOOD, 64'd300);
    check("sat8_ev8", 64'(rd_data_s8), 64'd255);
    check("wrap8_ev8", 64'(rd_data_w8), 64'd44);
    reset = 1'b1; step(); reset = 1'b0; step();

    // clear with coincident event
    pulse(9'h004, 5);
    ev = 9'h004; clr_en = 1'b1; clr_mask = 9'h004;
    step();
    ev = '0; clr_en = 1'b0; clr_mask = '0;
    read_chk("clr_pre_snap", EV_TX_GOOD, 64'd0);
    snapshot = 1'b1; step(); snapshot = 1'b0;
    read_chk("clr_post_snap", EV_TX_GOOD, 64'd1);

    // snapshot atomicity
    pulse(9'h001, 3);
    ev = 9'h001; snapshot = 1'b1; step(); ev = '0; snapshot = 1'b0;
    read_chk("snap_old", EV_TX_OVF, 64'd3);
    snapshot = 1'b1; step(); snapshot = 1'b0;
    read_chk("snap_new", EV_TX_OVF, 64'd4);

    // error interrupt on rx bad FCS
    pulse(9'h020, 1);
    step();
    check("err_masked_irq", 64'(irq), 64'd0);
    read_chk("err_status", 9, 64'h020);
    irq_mask = 9'h020;
    step();
    check("unmask_irq", 64'(irq), 64'd1);
    ev = 9'h020; irq_ack = 1'b1; step(); ev = '0; irq_ack = 1'b0;
    step();
    check("ack_set_wins_irq", 64'(irq), 64'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("ack_edge_irq", 64'(irq), 64'd1);
    step();
    check("ack_clean_irq", 64'(irq), 64'd0);

    // non-error event with everything unmasked
    irq_mask = 9'h1FF;
    pulse(9'h004, 1);
    step();
    step();
    check("nonerr_irq", 64'(irq), 64'd0);
    read_chk("nonerr_status", 9, 64'h000);

    // speed tracking
    spd = 2'b10; step(); step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    read_chk("speed10_status", 9, 64'h400);
    spd = 2'b01; step();
    check("speed01_out", 64'(speed), 64'd1);
    read_chk("speed_chg_status", 9, 64'hA00);

    // back-to-back reads over the whole address space
    for (int a = 0; a < 16; a++) exp_rd[a] = '0;
    exp_rd[EV_TX_OVF]  = 64'd4;
    exp_rd[EV_TX_GOOD] = 64'd1;
    exp_rd[9]          = 64'hA00;
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      exp_q.push_back(exp_rd[a]);
      step();
      check($sformatf("sweep_valid_%0d", a), 64'(rd_valid), 64'd1);
      check($sformatf("sweep_data_%0d", a), 64'(rd_data), exp_q.pop_front());
    end
    rd_en = 1'b0;
    step();
    check("hold_valid", 64'(rd_valid), 64'd0);
    check("hold_data", 64'(rd_data), 64'd0);

    // reset during a read
    rd_en = 1'b1; rd_addr = 4'd0; reset = 1'b1;
    step();
    check("rst_mid_valid", 64'(rd_valid), 64'd0);
    check("rst_mid_data", 64'(rd_data), 64'd0);
    check("rst_mid_irq", 64'(irq), 64'd0);
    check("rst_mid_speed", 64'(speed), 64'd0);
    rd_en = 1'b0; reset = 1'b0;
    step();
    snapshot = 1'b1; step(); snapshot = 1'b0;
    read_chk("post_rst_ev0", EV_TX_OVF, 64'd0);
    read_chk("post_rst_ev2", EV_TX_GOOD, 64'd0);
    read_chk("post_rst_ev8", EV_RX_GOOD, 64'd0);
    read_chk("post_rst_status", 9, 64'h200);
    step();
    check("post_hold_data", 64'(rd_data), 64'h200);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
